// File: rtl/audio_pkg.sv
`default_nettype none
// audio_pkg: note codes, sequencer state encoding and the tone half-period helper.
package audio_pkg;

  localparam logic [4:0] NOTE_REST = 5'd0;
  localparam logic [4:0] NOTE_C4   = 5'd1;
  localparam logic [4:0] NOTE_A4   = 5'd6;
  localparam logic [4:0] NOTE_C5   = 5'd8;
  localparam logic [4:0] NOTE_C8   = 5'd29;
  localparam logic [4:0] NOTE_END  = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Codes 1..29 walk C,D,E,F,G,A,B upward from C4; each octave doubles the base frequency.
  function automatic logic [23:0] half_period(input logic [4:0] code, input int clk_hz);
    int base;
    int oct;
    int idx;
    if (code == NOTE_REST || code > NOTE_C8) return 24'd0;
    idx = int'(code) - 1;
    oct = idx / 7;
    case (idx % 7)
      0:       base = 262;
      1:       base = 294;
      2:       base = 330;
      3:       base = 349;
      4:       base = 392;
      5:       base = 440;
      default: base = 494;
    endcase
    return 24'(clk_hz / (2 * (base << oct)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/tone_square_gen.sv
`default_nettype none
// tone_square_gen: 50%-duty square wave; a zero half-period means silence.
module tone_square_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] half_per,
  input  logic        restart,
  output logic        AIN
);

  logic [23:0] tone_cnt;

  always_ff @(posedge clk) begin
    if (reset || restart || half_per == 24'd0) begin
      tone_cnt <= 24'd0;
      AIN      <= 1'b0;
    end else if (tone_cnt == half_per - 24'd1) begin
      tone_cnt <= 24'd0;
      AIN      <= ~AIN;
    end else begin
      tone_cnt <= tone_cnt + 24'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tune_sequencer.sv
`default_nettype none
// tune_sequencer: plays one of NUM_TRACKS writable note sequences at a runtime tempo
// with start/stop/loop control, driving a square-wave audio pin.
module tune_sequencer
  import audio_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int NUM_TRACKS = 4,
  parameter int SONG_DEPTH = 64,
  parameter int BEAT_W     = 28,
  localparam int TRK_W     = $clog2(NUM_TRACKS),
  localparam int ADR_W     = $clog2(SONG_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TRK_W-1:0]  track_sel,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [BEAT_W-1:0] tempo_div,
  input  logic              wr_en,
  input  logic [TRK_W-1:0]  wr_track,
  input  logic [ADR_W-1:0]  wr_addr,
  input  logic [4:0]        wr_note,
  output logic              AIN,
  output logic              GAIN,
  output logic              SHUTDOWN,
  output logic              busy,
  output logic              done,
  output logic [ADR_W-1:0]  note_idx
);

  state_t            state, state_nxt;
  logic [4:0]        mem [NUM_TRACKS*SONG_DEPTH];
  logic [4:0]        cur_note;
  logic [4:0]        next_code;
  logic [4:0]        load_code;
  logic [TRK_W-1:0]  play_trk, trk_nxt;
  logic [ADR_W-1:0]  idx_nxt, next_slot;
  logic [BEAT_W-1:0] beat_cnt, beat_nxt, beat_lim;
  logic              load, beat_term, at_end, tone_restart;
  logic [23:0]       hp_lut [32];

  for (genvar i = 0; i < 32; i++) begin : g_hp_lut
    assign hp_lut[i] = half_period(5'(i), CLK_HZ);
  end

  // No reset on the note RAM: tunes survive a system reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_track, wr_addr}] <= wr_note;
  end

  assign beat_lim  = (tempo_div == '0) ? BEAT_W'(1) : tempo_div;
  assign beat_term = beat_cnt >= beat_lim - BEAT_W'(1);
  assign next_slot = note_idx + ADR_W'(1);
  assign next_code = mem[{play_trk, next_slot}];
  // An END sounding at slot 0 (only reachable via a load of slot 0) is a one-beat rest.
  assign at_end    = (note_idx == ADR_W'(SONG_DEPTH - 1)) || (next_code == NOTE_END) ||
                     (cur_note == NOTE_END);
  assign load_code = mem[{trk_nxt, idx_nxt}];

  always_comb begin
    state_nxt = state;
    trk_nxt   = play_trk;
    idx_nxt   = note_idx;
    beat_nxt  = beat_cnt;
    load      = 1'b0;
    case (state)
      ST_PLAY: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (start || track_sel != play_trk) begin
          load     = 1'b1;
          trk_nxt  = track_sel;
          idx_nxt  = '0;
          beat_nxt = '0;
        end else if (beat_term) begin
          beat_nxt = '0;
          if (!at_end) begin
            load    = 1'b1;
            idx_nxt = next_slot;
          end else if (loop_en) begin
            load    = 1'b1;
            idx_nxt = '0;
          end else begin
            state_nxt = ST_DONE;
          end
        end else begin
          beat_nxt = beat_cnt + BEAT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        if (start && !stop) begin
          state_nxt = ST_PLAY;
          load      = 1'b1;
          trk_nxt   = track_sel;
          idx_nxt   = '0;
          beat_nxt  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      play_trk <= '0;
      note_idx <= '0;
      beat_cnt <= '0;
      cur_note <= NOTE_REST;
    end else begin
      state    <= state_nxt;
      play_trk <= trk_nxt;
      note_idx <= idx_nxt;
      beat_cnt <= beat_nxt;
      if (load) cur_note <= load_code;
    end
  end

  // Phase restarts with each note load; leaving PLAY silences the pin on the same edge.
  assign tone_restart = load || (state_nxt != ST_PLAY);

  tone_square_gen u_tone (
    .clk      (clk),
    .reset    (reset),
    .half_per (hp_lut[cur_note]),
    .restart  (tone_restart),
    .AIN      (AIN)
  );

  assign GAIN     = 1'b1;
  assign SHUTDOWN = (state == ST_PLAY);
  assign busy     = (state == ST_PLAY);
  assign done     = (state == ST_DONE);

endmodule
`default_nettype wire
